// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Encodes instruction descriptions (ALU_R, ADDI, BEQ, J, LW, SW)
//               into 32-bit MIPS words, buffers them in a 2-entry FIFO and
//               tags each emitted word with an incrementing word address.
//               Sticky flags report accepted illegal kinds and address wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic              addr_wrap
);

    localparam logic [2:0] c_kind_alu_r = 3'd0;
    localparam logic [2:0] c_kind_addi  = 3'd1;
    localparam logic [2:0] c_kind_beq   = 3'd2;
    localparam logic [2:0] c_kind_j     = 3'd3;
    localparam logic [2:0] c_kind_lw    = 3'd4;
    localparam logic [2:0] c_kind_sw    = 3'd5;

    localparam logic [5:0] c_op_r    = 6'h00;
    localparam logic [5:0] c_op_addi = 6'h08;
    localparam logic [5:0] c_op_beq  = 6'h04;
    localparam logic [5:0] c_op_j    = 6'h02;
    localparam logic [5:0] c_op_lw   = 6'h23;
    localparam logic [5:0] c_op_sw   = 6'h2B;

    localparam logic [1:0]        c_cnt_one  = 2'd1;
    localparam logic [1:0]        c_cnt_full = 2'd2;
    localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    // r_mem0 is always the head; r_mem1 only holds data when two words wait.
    logic [31:0]       r_mem0;
    logic [31:0]       r_mem1;
    logic [1:0]        r_count;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;
    logic              r_wrap;

    logic [31:0]       w_enc;
    logic              w_legal;
    logic              w_full;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;

    // Combinational encoding of the incoming description; kinds 6-7 are illegal.
    always_comb begin
        w_enc   = 32'h0;
        w_legal = 1'b1;
        case (in_kind)
            c_kind_alu_r: w_enc = {c_op_r, in_rs, in_rt, in_rd, in_shamt, in_funct};
            c_kind_addi:  w_enc = {c_op_addi, in_rs, in_rt, in_imm};
            c_kind_beq:   w_enc = {c_op_beq,  in_rs, in_rt, in_imm};
            c_kind_j:     w_enc = {c_op_j, in_target};
            c_kind_lw:    w_enc = {c_op_lw,   in_rs, in_rt, in_imm};
            c_kind_sw:    w_enc = {c_op_sw,   in_rs, in_rt, in_imm};
            default:      w_legal = 1'b0;
        endcase
    end

    // Readiness depends only on FIFO occupancy, never on the consumer.
    assign w_full    = (r_count == c_cnt_full);
    assign in_ready  = !w_full && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_accept && w_legal;
    assign out_valid = (r_count != 2'd0);
    assign w_pop     = out_valid && out_ready;

    assign out_instr   = out_valid ? r_mem0 : 32'h0;
    assign out_addr    = r_addr;
    assign err_illegal = r_err;
    assign addr_wrap   = r_wrap;

    // FIFO storage and occupancy; push+pop only occurs with one entry (never full).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem0  <= 32'h0;
            r_mem1  <= 32'h0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_mem0 <= w_enc;
                    end else begin
                        r_mem1 <= w_enc;
                    end
                    r_count <= r_count + c_cnt_one;
                end
                2'b01: begin
                    r_mem0  <= r_mem1;
                    r_mem1  <= 32'h0;
                    r_count <= r_count - c_cnt_one;
                end
                2'b11: begin
                    r_mem0 <= w_enc;
                end
                default: begin
                end
            endcase
        end
    end

    // Word-address counter advances per emitted word; wrap flag is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_wrap <= 1'b0;
        end else if (w_pop) begin
            r_addr <= r_addr + c_addr_one;
            if (&r_addr) begin
                r_wrap <= 1'b1;
            end
        end
    end

    // Sticky illegal-kind flag, set when an illegal request is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept && !w_legal) begin
            r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Scoreboard bench for instr_encoder. The stimulus process
//               queues expected words from a reference encoder; a monitor
//               process compares every presented output against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    localparam int TB_AW    = 2;
    localparam int ADDR_MOD = 1 << TB_AW;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_kind = 3'd0;
    logic [4:0]       in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [5:0]       in_funct = '0;
    logic [15:0]      in_imm = '0;
    logic [25:0]      in_target = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_instr;
    logic [TB_AW-1:0] out_addr;
    logic             err_illegal;
    logic             addr_wrap;

    instr_encoder #(.ADDR_W(TB_AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err_illegal(err_illegal), .addr_wrap(addr_wrap)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] q[$];
    int          m_addr = 0;
    bit          m_err  = 1'b0;
    bit          m_wrap = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Opcode table indexed by kind; -1 marks the illegal kinds.
    function automatic int opcode_of(input int kind);
        case (kind)
            0: return 'h00;
            1: return 'h08;
            2: return 'h04;
            3: return 'h02;
            4: return 'h23;
            5: return 'h2B;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] ref_encode(input int kind, input int rs, input int rt,
                                               input int rd, input int sh, input int fn,
                                               input int imm, input int tgt);
        int op;
        op = opcode_of(kind);
        if (kind == 0)
            return 32'((op << 26) + (rs << 21) + (rt << 16) + (rd << 11) + (sh << 6) + fn);
        else if (kind == 3)
            return 32'((op << 26) + tgt);
        else
            return 32'((op << 26) + (rs << 21) + (rt << 16) + imm);
    endfunction

    // One stimulus cycle: drive, check readiness, record the accepted word.
    task automatic step(input bit v, input logic [2:0] k, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                        input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tgt,
                        input bit ordy, input bit use_gold, input logic [31:0] gold,
                        output bit acc);
        bit exp_ready;
        @(negedge clk);
        rst = 1'b0;
        in_valid = v; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_funct = fn; in_imm = imm; in_target = tgt; out_ready = ordy;
        #1;
        exp_ready = (q.size() < 2);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        acc = v && exp_ready;
        #2;
        if (acc) begin
            if (opcode_of(int'(k)) < 0) m_err = 1'b1;
            else if (use_gold) q.push_back(gold);
            else q.push_back(ref_encode(int'(k), int'(rs), int'(rt), int'(rd), int'(sh),
                                        int'(fn), int'(imm), int'(tgt)));
        end
    endtask

    task automatic idle(input bit ordy);
        bit a;
        step(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, ordy, 1'b0, 32'd0, a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("in_ready_rst", {31'd0, in_ready}, 32'd0);
        #2;
        q.delete();
        m_addr = 0; m_err = 1'b0; m_wrap = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1'b1);
        chk("drain_empty", 32'(q.size()), 32'd0);
        idle(1'b1);
    endtask

    // Monitor: compare DUT outputs with the model every cycle, pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
                chk("out_addr", 32'(out_addr), 32'(m_addr));
                chk("err_illegal", {31'd0, err_illegal}, {31'd0, m_err});
                chk("addr_wrap", {31'd0, addr_wrap}, {31'd0, m_wrap});
                if (q.size() != 0) begin
                    chk("out_instr", out_instr, q[0]);
                    if (out_ready) begin
                        void'(q.pop_front());
                        if (m_addr == ADDR_MOD - 1) m_wrap = 1'b1;
                        m_addr = (m_addr + 1) % ADDR_MOD;
                    end
                end else begin
                    chk("out_instr_empty", out_instr, 32'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit a;
        bit v;
        logic [2:0] k;
        do_reset();
        do_reset();

        // Single ALU_R add
        step(1, 3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 1, 1, 32'h00221820, a);
        drain();

        // Back-to-back ADDI, LW, J
        do_reset();
        step(1, 3'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0, 1, 1, 32'h20080005, a);
        step(1, 3'd4, 5'd29, 5'd9, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1, 1, 32'h8FA90004, a);
        step(1, 3'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000010, 1, 1, 32'h08000010, a);
        drain();

        // Full FIFO back-pressure
        do_reset();
        step(1, 3'd1, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001, 26'd0, 0, 0, 32'd0, a);
        step(1, 3'd2, 5'd2, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0002, 26'd0, 0, 0, 32'd0, a);
        step(1, 3'd5, 5'd3, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0003, 26'd0, 0, 0, 32'd0, a);
        chk("third_refused", {31'd0, a}, 32'd0);
        step(1, 3'd5, 5'd3, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0003, 26'd0, 1, 0, 32'd0, a);
        step(1, 3'd5, 5'd3, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0003, 26'd0, 0, 0, 32'd0, a);
        chk("third_accepted", {31'd0, a}, 32'd1);
        drain();

        // Illegal kind
        step(1, 3'd7, 5'd4, 5'd5, 5'd6, 5'd7, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1, 0, 32'd0, a);
        idle(1); idle(1); idle(1);

        // Address wrap with five words
        do_reset();
        for (int i = 0; i < 5; i++)
            step(1, 3'd1, 5'(i), 5'(i + 1), 5'd0, 5'd0, 6'd0, 16'(i * 7), 26'd0, 1, 0, 32'd0, a);
        drain();

        // Reset with two buffered words
        step(1, 3'd0, 5'd9, 5'd10, 5'd11, 5'd1, 6'h22, 16'd0, 26'd0, 0, 0, 32'd0, a);
        step(1, 3'd4, 5'd12, 5'd13, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0, 0, 0, 32'd0, a);
        do_reset();
        idle(1); idle(1); idle(1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            v = ($urandom_range(0, 9) < 7);
            k = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            step(v, k, 5'($urandom()), 5'($urandom()), 5'($urandom()), 5'($urandom()),
                 6'($urandom()), 16'($urandom()), 26'($urandom()),
                 ($urandom_range(0, 9) < 6), 0, 32'd0, a);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 8, is the width of the instruction-memory word-address counter.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  request carries a valid instruction description.
REQ-005 in_ready  output  1  encoder accepts a request this cycle.
REQ-006 in_kind  input  3  class: 0 ALU_R, 1 ADDI, 2 BEQ, 3 J, 4 LW, 5 SW, 6-7 illegal.
REQ-007 in_rs, in_rt, in_rd, in_shamt  input  5 each  register and shift fields.
REQ-008 in_funct  input  6  R-type function field.
REQ-009 in_imm  input  16  I-type immediate.
REQ-010 in_target  input  26  J-type word target.
REQ-011 out_valid  output  1  out_instr/out_addr hold a valid encoded word.
REQ-012 out_ready  input  1  consumer (imem loader) accepts the word.
REQ-013 out_instr  output  32  encoded MIPS instruction word.
REQ-014 out_addr  output  ADDR_W  word address for out_instr.
REQ-015 err_illegal  output  1  sticky flag: an illegal in_kind was accepted.
REQ-016 addr_wrap  output  1  sticky flag: out_addr wrapped from all-ones to 0.

Function
REQ-017 Input handshake completes on a cycle with in_valid && in_ready; output handshake completes on a cycle with out_valid && out_ready.
REQ-018 The block SHALL buffer encoded words in a 2-entry FIFO; in_ready = !full && !rst, with no dependence on out_ready.
REQ-019 Encoding: ALU_R -> {6'h00, rs, rt, rd, shamt, funct}.
REQ-020 Encoding: ADDI/BEQ/LW/SW -> {op, rs, rt, imm}, op = 6'h08/6'h04/6'h23/6'h2B respectively.
REQ-021 Encoding: J -> {6'h02, target}.
REQ-022 Latency: a word accepted at edge N SHALL appear with out_valid=1 after edge N when the FIFO was empty (one cycle, registered output).
REQ-023 Words SHALL leave in acceptance order; out_instr and out_addr stay stable while out_valid && !out_ready.
REQ-024 Illegal in_kind SHALL still be accepted when in_ready=1, is not enqueued, and sets err_illegal at the next edge.
REQ-025 out_addr SHALL equal the address counter; the counter increments by 1 on each output handshake, modulo 2^ADDR_W.
REQ-026 On the handshake where the counter goes from all-ones to 0, addr_wrap SHALL set at the same edge.
REQ-027 Simultaneous push and pop with 1 entry SHALL leave occupancy at 1 with the new word at the head next cycle; push with 0 entries and pop impossible (out_valid=0).
REQ-028 When full, in_ready=0; a simultaneous pop frees one slot, visible as in_ready=1 the following cycle.
REQ-029 out_valid = FIFO non-empty; out_instr = 32'h0 when empty.

Reset
REQ-030 While rst=1 at an edge: FIFO emptied, out_valid=0, out_instr=0, out_addr=0, err_illegal=0, addr_wrap=0.
REQ-031 While rst=1, in_ready=0; any in-flight or buffered word is discarded, not emitted.
REQ-032 First cycle after rst deasserts: in_ready=1, out_valid=0.

Verification
REQ-033 ALU_R rs=1 rt=2 rd=3 shamt=0 funct=6'h20, out_ready=1 -> next cycle out_instr=32'h00221820, out_addr=0; then out_addr=1.
REQ-034 ADDI rs=0 rt=8 imm=16'h0005; LW rs=29 rt=9 imm=16'h0004; J target=26'h0000010 back-to-back -> 32'h20080005, 32'h8FA90004, 32'h08000010 in order at addresses 0,1,2.
REQ-035 out_ready=0, three valid requests -> first two accepted, in_ready=0 on third; assert out_ready one cycle -> one pop, in_ready=1 next cycle, third accepted; order preserved.
REQ-036 in_kind=7 with in_valid=1 -> accepted, no out_valid, err_illegal=1 next cycle and held until rst.
REQ-037 ADDR_W=2, five words drained -> out_addr 0,1,2,3,0; addr_wrap=1 after fourth handshake.
REQ-038 Two words buffered, rst pulsed one cycle -> out_valid=0, out_addr=0, flags clear; no buffered word emitted after rst deasserts.
